// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the 1RW SRAM front-end.
//   state_e   : controller FSM states (IDLE, WR, RD0, RD1)
//   *_IDLE    : macro control pin levels while no access is in flight
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD0  = 2'd2,
    RD1  = 2'd3
  } state_e;

  // Macro control pins are active low; idle means deasserted.
  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;
  localparam logic OEB_IDLE = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Small synchronous FIFO holding read responses. The head word is kept in a
// register so rdata only changes on a push or a pop.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, wdata      enqueue wdata
//   pop              dequeue head (ignored when empty)
//   rdata            head of queue (registered)
//   full, empty      occupancy flags
//   count            number of stored entries
// -----------------------------------------------------------------------------
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(RSP_DEPTH):0]  count
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(RSP_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = rdata_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can leave it
    // unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head register: next stored word on pop, or the incoming word when it
    // becomes the head (queue empty, or the last entry popped in the same cycle).
    if (do_pop) begin
      if (count_q > CNT_W'(1)) rdata_d = mem_q[rd_ptr_d];
      else if (do_push)        rdata_d = wdata;
    end else if (do_push && empty) begin
      rdata_d = wdata;
    end
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // it has been written, as tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// -----------------------------------------------------------------------------
// sram_1rw_ctrl
// Valid/ready front-end for a single-port 1RW OpenRAM macro. Sequences the
// active-low macro pins from registered state, owns the bidirectional DATA
// bus, and queues read data in a response FIFO.
// Ports:
//   clk, rst                         clock (also the macro clock), sync reset
//   req_valid/req_ready              request handshake
//   req_we, req_addr, req_wdata      request payload (1 = write)
//   rsp_valid/rsp_ready, rsp_rdata   read response stream (FIFO head)
//   sram_data                        macro DATA (inout)
//   sram_addr, sram_csb, sram_web,   macro ADDR and active-low controls,
//   sram_oeb                         all registered
// -----------------------------------------------------------------------------
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic                  oeb_q, oeb_d;
  logic                  drive_q, drive_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  rd_slot;

  // A read is only admitted while a response slot is free, so the FIFO can
  // never overflow even with the consumer stalled.
  assign rd_slot   = (fifo_count < CNT_W'(RSP_DEPTH));
  assign req_ready = (state_q == IDLE) && (req_we || rd_slot);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_we) begin
            wdata_d = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD0;
          end
        end
      end
      WR:      state_d = IDLE;
      RD0:     state_d = RD1;
      RD1:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are decoded from the next state so the registered pins line up
    // with the state they belong to. OEb stays low across RD0 and RD1 and is
    // never low while the bus is driven.
    csb_d   = (state_d == IDLE) ? CSB_IDLE : 1'b0;
    web_d   = (state_d == WR)   ? 1'b0     : WEB_IDLE;
    oeb_d   = (state_d == RD0 || state_d == RD1) ? 1'b0 : OEB_IDLE;
    drive_d = (state_d == WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      csb_q   <= CSB_IDLE;
      web_q   <= WEB_IDLE;
      oeb_q   <= OEB_IDLE;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      oeb_q   <= oeb_d;
      drive_q <= drive_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_csb  = csb_q;
  assign sram_web  = web_q;
  assign sram_oeb  = oeb_q;
  assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // The macro output has been valid throughout RD1; capture it at the edge
  // that ends RD1. A reset on that edge clears the FIFO, discarding it.
  assign fifo_push = (state_q == RD1);
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (sram_data),
    .rdata (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw_ctrl
// Self-checking bench: a behavioural macro model on the pins, a transaction
// level reference (busy countdown, response queue, reference memory) compared
// against the DUT every cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_sram_1rw_ctrl;

  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_csb, sram_web, sram_oeb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .sram_data (sram_data),
    .sram_addr (sram_addr),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb)
  );

  // ---------------- macro model: synchronous 1RW, output gated by OEb -------
  logic [DW-1:0] mac_mem [1024];
  logic [DW-1:0] mac_dout;

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mac_mem[sram_addr] <= sram_data;
      else           mac_dout <= mac_mem[sram_addr];
    end
  end

  assign sram_data = !sram_oeb ? mac_dout : {DW{1'bz}};

  // ---------------- reference model -----------------------------------------
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] rq [$];
  int            busy     = 0;
  bit            op_wr    = 1'b0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] last_addr = '0;
  bit            model_ok = 1'b0;
  int            n_acc    = 0;
  int            cyc      = 0;

  function automatic bit m_ready();
    return (busy == 0) && (req_we || rq.size() < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    cyc++;
    if (rst) begin
      busy = 0;
      pend_cnt = 0;
      rq.delete();
      last_addr = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      rdy = m_ready();
      if (rq.size() > 0 && rsp_ready) void'(rq.pop_front());
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) rq.push_back(pend_data);
      end
      if (req_valid && rdy) begin
        n_acc++;
        last_addr = req_addr;
        op_wr = req_we;
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
          busy = 1;
        end else begin
          pend_data = ref_mem[req_addr];
          pend_cnt = 2;
          busy = 2;
        end
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("req_ready", req_ready, m_ready());
      check("rsp_valid", rsp_valid, rq.size() > 0);
      if (rq.size() > 0) check("rsp_rdata", rsp_rdata, rq[0]);
      check("sram_csb", sram_csb, !(busy > 0));
      check("sram_web", sram_web, !(busy > 0 && op_wr));
      check("sram_oeb", sram_oeb, !(busy > 0 && !op_wr));
      check("drive_en", dut.drive_q, busy > 0 && op_wr);
      check("sram_addr", sram_addr, last_addr);
      contention: assert (!(dut.drive_q && !sram_oeb && !sram_csb && sram_web)) else begin
        errors++;
        $display("FAIL contention: drive %0b oeb %0b csb %0b web %0b",
                 dut.drive_q, sram_oeb, sram_csb, sram_web);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one request and returns 2 time units after the accepting edge.
  task automatic send(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (req_ready) done = 1'b1;
    end
    #2;
    req_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  localparam logic [DW-1:0] D_WR = 128'hDEADBEEF_00000000_00000000_00000001;

  initial begin
    int  c0;
    int  guard;
    bit  done3;
    for (int i = 0; i < 1024; i++) begin
      mac_mem[i] = '0;
      ref_mem[i] = '0;
    end
    mac_dout  = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_csb", sram_csb, 1'b1);
    check("rst_web", sram_web, 1'b1);
    check("rst_oeb", sram_oeb, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_req_ready", req_ready, 1'b1);
    step();

    // Write then read back.
    send(1'b1, 10'h005, D_WR);
    @(negedge clk);
    check("wr_csb", sram_csb, 1'b0);
    check("wr_web", sram_web, 1'b0);
    check("wr_oeb", sram_oeb, 1'b1);
    step();
    send(1'b0, 10'h005, '0);
    repeat (2) @(negedge clk);
    check("rd_latency_early", rsp_valid, 1'b0);
    @(negedge clk);
    check("rd_latency_valid", rsp_valid, 1'b1);
    check("rd_data", rsp_rdata, D_WR);
    step();
    pop_one();

    // Back-to-back writes over the whole address space, data = address.
    c0 = cyc;
    for (int a = 0; a < 1024; a++) send(1'b1, AW'(a), DW'(a));
    check("b2b_cycles", DW'(cyc - c0), DW'(2047));
    send(1'b0, 10'h3FF, '0);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_rsp_valid", rsp_valid, 1'b1);
    check("wrap_rdata", rsp_rdata, DW'(10'h3FF));
    step();
    pop_one();

    // Backpressure: two responses fill the FIFO, a third read must wait.
    send(1'b0, 10'h001, '0);
    send(1'b0, 10'h002, '0);
    done3 = 1'b0;
    fork
      begin
        send(1'b0, 10'h003, '0);
        done3 = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    check("bp_req_ready", req_ready, 1'b0);
    check("bp_head1", rsp_rdata, DW'(1));
    step();
    pop_one();
    @(negedge clk);
    check("bp_head2", rsp_rdata, DW'(2));
    guard = 0;
    while (!done3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_third_accepted", done3, 1'b1);
    repeat (5) @(negedge clk);
    check("bp_head2_stable", rsp_rdata, DW'(2));
    step();
    pop_one();
    @(negedge clk);
    check("bp_head3", rsp_rdata, DW'(3));
    step();

    // Simultaneous push and pop with one entry (3) queued.
    send(1'b0, 10'h007, '0);
    step();
    pop_one();
    @(negedge clk);
    check("pp_valid", rsp_valid, 1'b1);
    check("pp_head", rsp_rdata, DW'(7));
    step();
    pop_one();
    @(negedge clk);
    check("pp_count1", rsp_valid, 1'b0);
    step();

    // Reset during RD0 aborts the read.
    send(1'b0, 10'h009, '0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rstmid_csb", sram_csb, 1'b1);
    check("rstmid_web", sram_web, 1'b1);
    check("rstmid_oeb", sram_oeb, 1'b1);
    check("rstmid_drive", dut.drive_q, 1'b0);
    check("rstmid_rsp_valid", rsp_valid, 1'b0);
    step();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid_no_rsp", rsp_valid, 1'b0);
    step();

    // Random traffic against the reference model.
    c0 = n_acc;
    guard = 0;
    while (n_acc - c0 < 10000 && guard < 60000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    check("rand_accepts", (n_acc - c0) >= 10000, 1'b1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) step();
    check("drain_empty", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
